// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Boot-time program loader. Assembles IW-bit instructions from
//               byte pairs on a valid/ready stream, writes them to consecutive
//               instruction-memory addresses from 0, and holds the fetch stage
//               halted until the image is complete.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
    parameter int IW = 9,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active-low
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [IW-1:0] wr_data,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LO    = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]  state;
    logic [AW:0] count;       // one extra bit so len = 2^AW needs no wrap
    logic [AW:0] len_q;
    logic [AW:0] count_next;

    assign count_next = count + 1'b1;

    // Handshake and status outputs decode directly from registered state,
    // so no path exists from in_valid/in_data to any output.
    assign in_ready = (state == S_LO) || (state == S_HI);
    assign wr_en    = (state == S_WRITE);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    // Load sequencer: byte assembly, address counting, hold and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= '0;
            len_q     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b1;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        count     <= '0;
                        err       <= 1'b0;
                        core_hold <= 1'b1;
                        state     <= (len == '0) ? S_DONE : S_LO;
                    end
                end
                S_LO: begin
                    if (in_valid) begin
                        wr_data[7:0] <= in_data;
                        state        <= S_HI;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        wr_data[IW-1] <= in_data[0];
                        // Address is captured here rather than decoded from
                        // count so it never shows the post-increment value.
                        wr_addr       <= count[AW-1:0];
                        if (in_data[7:1] != 7'd0) begin
                            err <= 1'b1;
                        end
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    count <= count_next;
                    state <= (count_next == len_q) ? S_DONE : S_LO;
                end
                S_DONE: begin
                    core_hold <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_loader
// Description : Scoreboard bench for inst_loader. Stimulus pushes expected
//               {addr,data} writes into a queue; a monitor pops and compares
//               on every wr_en cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;

    logic [22:0] outs;
    assign outs = {in_ready, wr_en, wr_addr, wr_data, core_hold, busy, done, err};
    localparam logic [22:0] RST_OUTS = 23'h000008;   // only core_hold set

    int passed = 0;
    int total  = 0;
    int writes = 0;
    int dones  = 0;
    logic [16:0] exp_q[$];

    inst_loader #(.IW(9), .AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [8:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every write the DUT presents is compared to the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (wr_en) begin
                writes++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                             wr_addr, wr_data);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e[16:9]));
                    check("wr_data", 32'(wr_data), 32'(e[8:0]));
                end
            end
            if (done) dones++;
        end
    end

    // Pulse start with the given length; returns one tick after the accepting edge.
    task automatic do_start(input logic [8:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte, optionally after a random idle gap; returns after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        if (gaps) begin
            int n;
            in_valid = 1'b0;
            n = $urandom_range(0, 2);
            repeat (n) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL byte_accept_timeout: got in_ready 0 for 50 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 2000 && !found; t++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) begin
            total++;
            $display("FAIL done_timeout: got no done pulse, required one");
        end
    endtask

    logic [7:0] img [6] = '{8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};

    initial begin
        int w0;
        int d0;
        reset = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;

        // Reset values, during and after reset.
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(outs), 32'(RST_OUTS));
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'(outs), 32'(RST_OUTS));
        end

        // Basic load with in_valid held high and cycle-exact timing.
        push_exp(8'd0, 9'h112);
        push_exp(8'd1, 9'h034);
        push_exp(8'd2, 9'h1FF);
        do_start(9'd3);
        fork
            for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
            for (int k = 1; k <= 11; k++) begin
                @(negedge clk);
                check("basic_wr_en_cycle", 32'(wr_en), 32'(k == 3 || k == 6 || k == 9));
                check("basic_done_cycle",  32'(done),  32'(k == 10));
                check("basic_core_hold",   32'(core_hold), 32'(k <= 10));
                check("basic_busy",        32'(busy),  32'(k <= 10));
            end
        join
        check("basic_err", 32'(err), 32'd0);

        // Random gaps plus an ignored start pulse carrying a different length.
        w0 = writes;
        push_exp(8'd0, 9'h112);
        push_exp(8'd1, 9'h034);
        push_exp(8'd2, 9'h1FF);
        do_start(9'd3);
        fork
            for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1; start = 1'b1; len = 9'd1;
                @(posedge clk); #1; start = 1'b0;
            end
        join
        wait_done();
        repeat (3) @(negedge clk);
        check("gaps_write_count", 32'(writes - w0), 32'd3);
        check("gaps_queue_empty", 32'(exp_q.size()), 32'd0);

        // Framing error on a HI byte; instruction still written, err sticky.
        push_exp(8'd0, 9'h145);
        push_exp(8'd1, 9'h010);
        do_start(9'd2);
        send_byte(8'h45, 1'b0);
        send_byte(8'h83, 1'b0);
        @(negedge clk);
        check("frame_err_set", 32'(err), 32'd1);
        send_byte(8'h10, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done();
        check("frame_err_at_done", 32'(err), 32'd1);
        @(negedge clk);
        check("frame_hold_released", 32'(core_hold), 32'd0);
        check("frame_err_after_done", 32'(err), 32'd1);

        // Zero-length load clears err and completes with no writes.
        w0 = writes;
        do_start(9'd0);
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_err_cleared", 32'(err), 32'd0);
        check("len0_hold", 32'(core_hold), 32'd1);
        @(negedge clk);
        check("len0_hold_released", 32'(core_hold), 32'd0);
        check("len0_done_single", 32'(done), 32'd0);
        check("len0_no_writes", 32'(writes - w0), 32'd0);

        // Full depth: 256 instructions, addresses 0..255, one done.
        w0 = writes;
        d0 = dones;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push_exp(b, {b[0], b});
        end
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_byte(b, 1'b0);
            send_byte({7'd0, b[0]}, 1'b0);
        end
        wait_done();
        repeat (4) @(negedge clk);
        check("full_write_count", 32'(writes - w0), 32'd256);
        check("full_done_count", 32'(dones - d0), 32'd1);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after two writes.
        push_exp(8'd0, 9'h1AA);
        push_exp(8'd1, 9'h055);
        do_start(9'd4);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        send_byte(8'h11, 1'b0);
        #2;
        reset = 1'b0;
        w0 = writes;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_wr_en", 32'(wr_en), 32'd0);
            check("rst_mid_core_hold", 32'(core_hold), 32'd1);
            check("rst_mid_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_mid_queue_drained", 32'(exp_q.size()), 32'd0);
        push_exp(8'd0, 9'h07A);
        do_start(9'd1);
        send_byte(8'h7A, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);
        check("reload_write_count", 32'(writes - w0), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
